// File: rtl/seq_mult_hs.sv
// Shift-add sequential multiplier with start/busy/done handshake.
// One partial product per clock. In signed mode the operand magnitudes are
// multiplied and the product sign is applied once, in the final state.
module seq_mult_hs #(
    parameter int WIDTH = 4
) (
    input  logic                 topclock,
    input  logic                 topreset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multa,
    input  logic [WIDTH-1:0]     multb,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   topout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mag_a;   // shifted left one place per CALC cycle
    logic [WIDTH-1:0]     mag_b;   // shifted right one place per CALC cycle
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic                 sign_a;
    logic                 sign_b;

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned
    always_comb begin
        sign_a = signed_mode & multa[WIDTH-1];
        sign_b = signed_mode & multb[WIDTH-1];
        abs_a  = sign_a ? (~multa + WIDTH'(1)) : multa;
        abs_b  = sign_b ? (~multb + WIDTH'(1)) : multb;
    end

    // Control FSM and datapath; all outputs are registered
    always_ff @(posedge topclock) begin
        if (topreset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            topout <= '0;
            acc    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= {{WIDTH{1'b0}}, abs_a};
                        mag_b <= abs_b;
                        neg   <= sign_a ^ sign_b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // mag_a/mag_b are pre-shifted, so bit 0 of mag_b is magB[cnt]
                    // and mag_a equals magA << cnt
                    if (mag_b[0]) begin
                        acc <= acc + mag_a;
                    end
                    mag_a <= mag_a << 1;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    topout <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Self-checking bench for seq_mult_hs: WIDTH=4 and WIDTH=8 instances.
module tb_seq_mult_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, sm4;
    logic [3:0] a4, b4;
    logic       busy4, done4;
    logic [7:0] out4;

    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] out8;

    seq_mult_hs #(.WIDTH(4)) dut4 (
        .topclock(clk), .topreset(rst), .start(start4), .signed_mode(sm4),
        .multa(a4), .multb(b4), .busy(busy4), .done(done4), .topout(out4)
    );

    seq_mult_hs #(.WIDTH(8)) dut8 (
        .topclock(clk), .topreset(rst), .start(start8), .signed_mode(sm8),
        .multa(a8), .multb(b8), .busy(busy8), .done(done8), .topout(out8)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       sm;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec4_t;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Launch one WIDTH=4 op and check busy/done every cycle up to the done pulse
    task automatic op4(input string name, input logic sm, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] exp);
        @(negedge clk);
        sm4 = sm; a4 = a; b4 = b; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0; a4 = ~a; b4 = ~b; sm4 = ~sm;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 5) begin
                check({name, " busy"}, 16'(busy4), 16'd1);
                check({name, " done"}, 16'(done4), 16'd0);
            end else begin
                check({name, " busy@done"}, 16'(busy4), 16'd0);
                check({name, " done"}, 16'(done4), 16'd1);
                check({name, " topout"}, 16'(out4), 16'(exp));
            end
        end
    endtask

    task automatic op8(input string name, input logic sm, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp);
        @(negedge clk);
        sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = ~a; b8 = ~b; sm8 = ~sm;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 9) begin
                check({name, " busy"}, 16'(busy8), 16'd1);
                check({name, " done"}, 16'(done8), 16'd0);
            end else begin
                check({name, " busy@done"}, 16'(busy8), 16'd0);
                check({name, " done"}, 16'(done8), 16'd1);
                check({name, " topout"}, out8, exp);
            end
        end
    endtask

    initial begin
        vec4_t vecs[9];
        logic       b2b_sm[4];
        logic [3:0] b2b_a[4];
        logic [3:0] b2b_b[4];
        logic [7:0] b2b_exp[4];
        int idx, last, cyc, ndone;

        vecs[0] = '{1'b0, 4'hB, 4'hD, 8'h8F};  // 11*13 = 143
        vecs[1] = '{1'b1, 4'hB, 4'h3, 8'hF1};  // -5*3 = -15
        vecs[2] = '{1'b0, 4'hB, 4'h3, 8'h21};  // 11*3 = 33
        vecs[3] = '{1'b0, 4'hF, 4'hF, 8'hE1};  // 225
        vecs[4] = '{1'b1, 4'h8, 4'h8, 8'h40};  // -8*-8 = 64
        vecs[5] = '{1'b0, 4'h0, 4'hF, 8'h00};
        vecs[6] = '{1'b0, 4'hF, 4'h0, 8'h00};
        vecs[7] = '{1'b1, 4'h7, 4'h8, 8'hC8};  // 7*-8 = -56
        vecs[8] = '{1'b1, 4'hF, 4'hF, 8'h01};  // -1*-1 = 1

        rst = 1'b1; start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy4", 16'(busy4), 16'd0);
        check("reset done4", 16'(done4), 16'd0);
        check("reset topout4", 16'(out4), 16'd0);
        check("reset busy8", 16'(busy8), 16'd0);
        check("reset topout8", out8, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            op4($sformatf("vec%0d", i), vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Back-to-back with start held high through each done cycle
        b2b_sm[0] = 1'b0; b2b_a[0] = 4'hF; b2b_b[0] = 4'hF; b2b_exp[0] = 8'hE1;
        b2b_sm[1] = 1'b1; b2b_a[1] = 4'h8; b2b_b[1] = 4'h8; b2b_exp[1] = 8'h40;
        b2b_sm[2] = 1'b0; b2b_a[2] = 4'h0; b2b_b[2] = 4'hF; b2b_exp[2] = 8'h00;
        b2b_sm[3] = 1'b0; b2b_a[3] = 4'hF; b2b_b[3] = 4'h0; b2b_exp[3] = 8'h00;
        @(negedge clk);
        sm4 = b2b_sm[0]; a4 = b2b_a[0]; b4 = b2b_b[0]; start4 = 1'b1;
        idx = 0; last = -1; cyc = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            @(negedge clk);
            cyc++;
            if (done4) begin
                check($sformatf("b2b%0d topout", idx), 16'(out4), 16'(b2b_exp[idx]));
                if (last < 0) check("b2b first latency", 16'(cyc), 16'd6);
                else check($sformatf("b2b%0d spacing", idx), 16'(cyc - last), 16'd6);
                last = cyc;
                idx++;
                if (idx < 4) begin
                    sm4 = b2b_sm[idx]; a4 = b2b_a[idx]; b4 = b2b_b[idx];
                end else begin
                    start4 = 1'b0;
                end
            end
        end
        start4 = 1'b0;
        check("b2b done count", 16'(idx), 16'd4);
        repeat (8) @(negedge clk);

        // Start while busy must be ignored
        sm4 = 1'b0; a4 = 4'hA; b4 = 4'h5; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a4 = 4'h1; b4 = 4'hF; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done4) begin
                ndone++;
                check("busy-start topout", 16'(out4), 16'h0032);
            end
        end
        check("busy-start done count", 16'(ndone), 16'd1);

        // Reset in the middle of an operation
        @(negedge clk);
        sm4 = 1'b0; a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset busy", 16'(busy4), 16'd0);
        check("midreset done", 16'(done4), 16'd0);
        check("midreset topout", 16'(out4), 16'd0);
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done4) ndone++;
        end
        check("midreset no done", 16'(ndone), 16'd0);
        op4("after reset 1*15", 1'b0, 4'h1, 4'hF, 8'h0F);

        // WIDTH=8 instance
        op8("w8 255*255", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        op8("w8 -128*127", 1'b1, 8'h80, 8'h7F, 16'hC080);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
